// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART threshold controller and its TX echo path.
package uart_ctrl_pkg;

  localparam int DEF_CLKS_PER_BIT = 2;

  localparam logic [7:0] CMD_SEL_A = 8'h41;
  localparam logic [7:0] CMD_SEL_B = 8'h42;
  localparam logic [7:0] CMD_SEL_C = 8'h43;
  localparam logic [7:0] CMD_SEL_D = 8'h44;
  localparam logic [7:0] CMD_SEL_E = 8'h45;
  localparam logic [7:0] CMD_SEL_F = 8'h46;
  localparam logic [7:0] CMD_SEL_G = 8'h47;
  localparam logic [7:0] CMD_SEL_H = 8'h48;
  localparam logic [7:0] CMD_SEL_I = 8'h49;
  localparam logic [7:0] CMD_INC   = 8'h77;
  localparam logic [7:0] CMD_DEC   = 8'h73;

  localparam logic signed [7:0] S8_MAX = 8'sd127;
  localparam logic signed [7:0] S8_MIN = -8'sd128;

  typedef enum logic [3:0] {
    SEL_SOLAR,
    SEL_SOLAR_COOL,
    SEL_SOLAR_HEAT,
    SEL_GH_COOL,
    SEL_GH_HEAT,
    SEL_AMB_COOL,
    SEL_AMB_HEAT,
    SEL_GEO_COOL,
    SEL_GEO_HEAT
  } sel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
module uart_tx
  import uart_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle_ready
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);

  uart_st_e         st, st_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
      idx <= '0;
      tx  <= 1'b1;
    end else begin
      st  <= st_d;
      cnt <= cnt_d;
      idx <= idx_d;
      tx  <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_d;
  end

  // Bit currently on the line is always shift[0]; shift right at each data-bit boundary.
  always_comb begin
    st_d    = st;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    tx_d    = tx;
    case (st)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          shift_d = data;
          tx_d    = 1'b0;
          cnt_d   = '0;
          st_d    = ST_START;
        end
      end
      ST_START: begin
        if (cnt == LAST_C) begin
          cnt_d = '0;
          idx_d = '0;
          tx_d  = shift[0];
          st_d  = ST_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt == LAST_C) begin
          cnt_d = '0;
          if (idx == 3'd7) begin
            tx_d = 1'b1;
            st_d = ST_STOP;
          end else begin
            idx_d   = idx + 3'd1;
            shift_d = {1'b0, shift[7:1]};
            tx_d    = shift[1];
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt == LAST_C) begin
          cnt_d = '0;
          st_d  = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign idle_ready = (st == ST_IDLE);

endmodule

// File: rtl/uart_threshold_controller.sv
// UART command front-end: selects one of nine thresholds, steps it with saturation, echoes bytes.
module uart_threshold_controller
  import uart_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [15:0]       solar_th,
  output logic signed [7:0] solar_cooldown_th,
  output logic signed [7:0] solar_heatup_th,
  output logic signed [7:0] greenhouse_cooldown_th,
  output logic signed [7:0] greenhouse_heatup_th,
  output logic signed [7:0] ambient_cooldown_th,
  output logic signed [7:0] ambient_heatup_th,
  output logic signed [7:0] geothermal_cooldown_th,
  output logic signed [7:0] geothermal_heatup_th,
  output logic              tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

  function automatic logic signed [7:0] sat_step_s8(input logic signed [7:0] v, input logic up);
    if (up) return (v == S8_MAX) ? v : v + 8'sd1;
    else    return (v == S8_MIN) ? v : v - 8'sd1;
  endfunction

  function automatic logic [15:0] sat_step_u16(input logic [15:0] v, input logic up);
    if (up) return (v == 16'hFFFF) ? v : v + 16'd1;
    else    return (v == 16'h0000) ? v : v - 16'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous rx line
  logic rx_sync_p0, rx_sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // Stage p2: receiver FSM, rx_valid qualifies rx_shift
  uart_st_e         rx_st, rx_st_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_idx, rx_idx_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic             rx_valid, rx_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st    <= ST_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_st    <= rx_st_d;
      rx_cnt   <= rx_cnt_d;
      rx_idx   <= rx_idx_d;
      rx_valid <= rx_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_d;
  end

  always_comb begin
    rx_st_d    = rx_st;
    rx_cnt_d   = rx_cnt;
    rx_idx_d   = rx_idx;
    rx_shift_d = rx_shift;
    rx_valid_d = 1'b0;
    case (rx_st)
      ST_IDLE: begin
        if (!rx_sync_p1) begin
          rx_cnt_d = '0;
          rx_st_d  = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt == HALF_C) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_st_d  = rx_sync_p1 ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt == LAST_C) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_p1, rx_shift[7:1]};
          if (rx_idx == 3'd7) rx_st_d  = ST_STOP;
          else                rx_idx_d = rx_idx + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_cnt == LAST_C) begin
          rx_cnt_d   = '0;
          rx_valid_d = rx_sync_p1;
          rx_st_d    = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_st_d = ST_IDLE;
    endcase
  end

  // Stage p3: command decode and saturating threshold update
  sel_e              sel;
  logic [15:0]       solar_q;
  logic signed [7:0] th_s [8];
  logic              is_sel, is_inc, is_dec;
  logic [2:0]        s_idx;

  assign is_sel = (rx_shift >= CMD_SEL_A) && (rx_shift <= CMD_SEL_I);
  assign is_inc = (rx_shift == CMD_INC);
  assign is_dec = (rx_shift == CMD_DEC);
  assign s_idx  = 3'(4'(sel) - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel     <= SEL_SOLAR;
      solar_q <= '0;
      for (int i = 0; i < 8; i++) th_s[i] <= '0;
    end else if (rx_valid) begin
      if (is_sel) begin
        sel <= sel_e'(4'(rx_shift - CMD_SEL_A));
      end else if (is_inc || is_dec) begin
        if (sel == SEL_SOLAR) solar_q     <= sat_step_u16(solar_q, is_inc);
        else                  th_s[s_idx] <= sat_step_s8(th_s[s_idx], is_inc);
      end
    end
  end

  assign solar_th               = solar_q;
  assign solar_cooldown_th      = th_s[0];
  assign solar_heatup_th        = th_s[1];
  assign greenhouse_cooldown_th = th_s[2];
  assign greenhouse_heatup_th   = th_s[3];
  assign ambient_cooldown_th    = th_s[4];
  assign ambient_heatup_th      = th_s[5];
  assign geothermal_cooldown_th = th_s[6];
  assign geothermal_heatup_th   = th_s[7];

  // Stage p3: one-entry echo buffer; a byte arriving while it is occupied is not echoed
  logic       echo_full;
  logic [7:0] echo_byte;
  logic       tx_idle_ready;
  logic       tx_start;

  assign tx_start = echo_full && tx_idle_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       echo_full <= 1'b0;
    else if (rx_valid && !echo_full) echo_full <= 1'b1;
    else if (tx_start)              echo_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_valid && !echo_full) echo_byte <= rx_shift;
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .start      (tx_start),
    .data       (echo_byte),
    .tx         (tx),
    .idle_ready (tx_idle_ready)
  );

endmodule

// File: tb/tb_uart_threshold_controller.sv
// Directed bench: drives UART command frames and decodes the echo line independently.
module tb_uart_threshold_controller;

  localparam int CPB = 2;
  localparam int GAP = 4;

  logic              clk;
  logic              rst;
  logic              rx;
  logic [15:0]       solar_th;
  logic signed [7:0] solar_cooldown_th, solar_heatup_th;
  logic signed [7:0] greenhouse_cooldown_th, greenhouse_heatup_th;
  logic signed [7:0] ambient_cooldown_th, ambient_heatup_th;
  logic signed [7:0] geothermal_cooldown_th, geothermal_heatup_th;
  logic              tx;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_th [9];
  logic [7:0]  echo_q [$];

  uart_threshold_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rx                     (rx),
    .solar_th               (solar_th),
    .solar_cooldown_th      (solar_cooldown_th),
    .solar_heatup_th        (solar_heatup_th),
    .greenhouse_cooldown_th (greenhouse_cooldown_th),
    .greenhouse_heatup_th   (greenhouse_heatup_th),
    .ambient_cooldown_th    (ambient_cooldown_th),
    .ambient_heatup_th      (ambient_heatup_th),
    .geothermal_cooldown_th (geothermal_cooldown_th),
    .geothermal_heatup_th   (geothermal_heatup_th),
    .tx                     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] th_of(input int i);
    case (i)
      0: return solar_th;
      1: return {8'h00, solar_cooldown_th};
      2: return {8'h00, solar_heatup_th};
      3: return {8'h00, greenhouse_cooldown_th};
      4: return {8'h00, greenhouse_heatup_th};
      5: return {8'h00, ambient_cooldown_th};
      6: return {8'h00, ambient_heatup_th};
      7: return {8'h00, geothermal_cooldown_th};
      default: return {8'h00, geothermal_heatup_th};
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_th%0d", tag, i), 32'(th_of(i)), 32'(exp_th[i]));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 9; i++) exp_th[i] = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic drain();
    repeat (30) @(negedge clk);
    echo_q.delete();
  endtask

  // Echo line decoder; a frame overlapped by reset is discarded
  always begin
    logic [7:0] b;
    logic       stop_b;
    logic       aborted;
    @(negedge clk);
    if (rst === 1'b1 && tx === 1'b0) begin
      aborted = 1'b0;
      b       = '0;
      stop_b  = 1'b0;
      for (int k = 0; k < 9; k++) begin
        repeat (CPB) @(negedge clk);
        if (rst !== 1'b1) aborted = 1'b1;
        if (k < 8) b[k] = tx;
        else       stop_b = tx;
      end
      if (!aborted) begin
        chk("echo_stop", 32'(stop_b), 32'd1);
        echo_q.push_back(b);
      end
    end
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    clear_exp();

    repeat (10) @(negedge clk);
    check_all("rst");
    chk("rst_tx", 32'(tx), 32'd1);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_all("idle");
    chk("idle_tx", 32'(tx), 32'd1);

    send_byte(8'h41, 1'b1);
    check_all("selA");
    send_byte(8'h77, 1'b1);
    exp_th[0] = 16'd1;
    check_all("A_inc");
    send_byte(8'h73, 1'b1);
    exp_th[0] = 16'd0;
    check_all("A_dec");
    repeat (30) @(negedge clk);
    chk("echo3_n", 32'(echo_q.size()), 32'd3);
    if (echo_q.size() == 3) begin
      chk("echo3_0", 32'(echo_q[0]), 32'h41);
      chk("echo3_1", 32'(echo_q[1]), 32'h77);
      chk("echo3_2", 32'(echo_q[2]), 32'h73);
    end
    echo_q.delete();

    send_byte(8'h42, 1'b1);
    send_byte(8'h73, 1'b1);
    exp_th[1] = 16'h00FF;
    check_all("B_dec");
    send_byte(8'h77, 1'b1);
    send_byte(8'h77, 1'b1);
    exp_th[1] = 16'h0001;
    check_all("B_inc2");

    send_byte(8'h49, 1'b1);
    for (int i = 0; i < 130; i++) send_byte(8'h77, 1'b1);
    exp_th[8] = 16'h007F;
    check_all("I_sat_hi");

    send_byte(8'h43, 1'b1);
    for (int i = 0; i < 129; i++) send_byte(8'h73, 1'b1);
    exp_th[2] = 16'h0080;
    check_all("C_sat_lo");

    send_byte(8'h41, 1'b1);
    send_byte(8'h73, 1'b1);
    check_all("A_sat0");
    drain();

    send_byte(8'h77, 1'b0);
    check_all("frame_err");
    repeat (30) @(negedge clk);
    chk("frame_err_echo", 32'(echo_q.size()), 32'd0);

    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (25) @(negedge clk);
    check_all("glitch");
    repeat (30) @(negedge clk);
    chk("glitch_echo", 32'(echo_q.size()), 32'd0);
    echo_q.delete();

    send_byte(8'h78, 1'b1);
    check_all("unk_x");
    send_byte(8'h77, 1'b1);
    exp_th[0] = 16'd1;
    check_all("x_then_w");
    repeat (30) @(negedge clk);
    chk("echo_x_n", 32'(echo_q.size()), 32'd2);
    if (echo_q.size() == 2) begin
      chk("echo_x_0", 32'(echo_q[0]), 32'h78);
      chk("echo_x_1", 32'(echo_q[1]), 32'h77);
    end
    echo_q.delete();

    // 'A' echo is on the line while the following 'w' frame is cut by reset
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h77 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    #2;
    rst = 1'b0;
    rx  = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    clear_exp();
    repeat (4) @(negedge clk);
    check_all("midrst_low");
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check_all("midrst_after");
    echo_q.delete();
    send_byte(8'h77, 1'b1);
    exp_th[0] = 16'd1;
    check_all("midrst_w");
    repeat (30) @(negedge clk);
    chk("midrst_echo_n", 32'(echo_q.size()), 32'd1);
    if (echo_q.size() == 1) chk("midrst_echo", 32'(echo_q[0]), 32'h77);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_threshold_controller.md
# uart_threshold_controller

Serial command front-end for the thermal controller. It receives 8N1 UART bytes on `rx`, decodes single-character commands that select one of nine threshold registers and step it up or down, and drives those thresholds to the control datapath. Every validly framed byte is echoed on `tx` through an internal `uart_tx` instance, which is also reused by benches as a stimulus source.

## Interface
- `CLKS_PER_BIT`, default 2: clock cycles per UART bit, shared by RX and TX. Deployments override it, e.g. 868 for 100 MHz / 115200.
- `clk` in 1: single system clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx` in 1: UART receive line; idles high.
- `solar_th` out 16: unsigned solar threshold.
- `solar_cooldown_th`, `solar_heatup_th` out 8: signed thresholds.
- `greenhouse_cooldown_th`, `greenhouse_heatup_th` out 8: signed thresholds.
- `ambient_cooldown_th`, `ambient_heatup_th` out 8: signed thresholds.
- `geothermal_cooldown_th`, `geothermal_heatup_th` out 8: signed thresholds.
- `tx` out 1: UART echo line; idles high.

## Operation
- **Reset values:**
  - All threshold outputs are 0.
  - The selection register is `A` (`solar_th`).
  - `tx` is 1.
  - RX and TX state machines are IDLE.
- **Frame format:** 8N1, LSB first. The receiver does not check parity, because 8N1 carries none.
- **RX state machine:**
  - States: IDLE, START, DATA, STOP.
  - IDLE → START on `rx`=0.
  - In START, `rx` is re-sampled at CLKS_PER_BIT/2. If it reads 1, the receiver returns to IDLE (glitch).
  - DATA takes 8 samples, one every CLKS_PER_BIT cycles, at mid-bit.
  - In STOP, if the stop sample is 1, `rx_valid` pulses for one cycle with the byte. If it is 0, the byte is discarded (framing error).
- **Command decode** (on `rx_valid`, case-sensitive):
  - `A`..`I` (0x41–0x49) select, in order: `solar_th`, `solar_cooldown_th`, `solar_heatup_th`, `greenhouse_cooldown_th`, `greenhouse_heatup_th`, `ambient_cooldown_th`, `ambient_heatup_th`, `geothermal_cooldown_th`, `geothermal_heatup_th`.
  - `w` (0x77) adds 1 to the selected register.
  - `s` (0x73) subtracts 1 from the selected register.
  - Any other byte changes no register and leaves the selection unchanged.
- **Saturation rules:**
  - Signed registers saturate at +127 and −128.
  - `solar_th` saturates at 0 and 65535.
  - There is no wrap-around.
- **Echo:**
  - Every valid byte, including unknown ones, is loaded into a one-entry echo buffer.
  - The buffer is handed to `uart_tx` when `idle_ready`=1.
  - If the buffer is already full, the new echo is dropped. Register updates still occur.
- **`uart_tx` sub-module:**
  - Ports: `clk`, `rst`, `start`, `data[7:0]`, `tx`, `idle_ready`.
  - States: IDLE, START, DATA, STOP.
  - In IDLE, `idle_ready`=1 and `tx`=1.
  - A one-cycle `start` pulse while idle latches `data`. The module then sends a start bit (0), 8 data bits LSB first, and a stop bit (1), each lasting CLKS_PER_BIT cycles.
  - `start` is ignored while busy.
  - `idle_ready` returns to 1 the cycle after the stop bit ends.

## Timing
- **Frame length:** 10·CLKS_PER_BIT cycles, which is 20 cycles at the default. Senders issue bytes at least 22 cycles apart.
- **`rx_valid` latency:** asserts the cycle after the stop-bit sample.
- **Register update:** outputs change on the edge after `rx_valid`, one cycle later.
- **Echo latency:** `tx` falls (start bit) 2 cycles after `rx_valid` if the transmitter was idle.
- **Outputs:** registered and glitch-free.
- **Asynchronous reset mid-frame:**
  - All state machines return to IDLE and thresholds return to reset values.
  - A partial byte is lost.
  - `tx` goes high immediately.
  - Reception resumes on the next falling edge after `rst` deasserts.
- **Back-to-back commands:** a byte received while the previous echo is still transmitting is still decoded.

## Structure
- **Package `uart_ctrl_pkg`:**
  - Command constants: `CMD_SEL_A`..`CMD_SEL_I`, `CMD_INC`=`w`, `CMD_DEC`=`s`.
  - Select-index enum (9 values).
  - Default `CLKS_PER_BIT`.
  - Signed-8 limits.
- **Sub-modules:**
  - `uart_tx` is a standalone sub-module with the port list above.
  - The receiver and decoder stay inline in `uart_threshold_controller`.

## Test plan
- **Reset:** assert `rst`=0 for 10 cycles → all thresholds 0, `tx`=1; deassert, idle 20 cycles → no change.
- **Select A, step:** send `A`, `w`, `s` → `solar_th` goes 0→1→0; `tx` echoes 0x41, 0x77, 0x73 bit-exact.
- **Signed register:** send `B`, `s` → `solar_cooldown_th`=8'hFF (−1); then `w`, `w` → +1; all other outputs stay 0.
- **Saturation:**
  - `I` then 130×`w` → `geothermal_heatup_th`=127.
  - `A` then `s` at 0 → `solar_th` stays 0.
- **Error paths:**
  - A frame with stop bit 0 → no register change, no echo.
  - Byte `x` → echo 0x78 only; selection unchanged, so a following `w` increments the previous selection.
- **Reset mid-frame:** pulse `rst` low during DATA of `w` → no increment; the next full `w` is decoded normally.
